// File: rtl/mem_rd_streamer.sv
// Burst memory reader: issues sequential word addresses to a synchronous-read
// memory and streams the returned data through a small credit-managed FIFO.
module mem_rd_streamer #(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [15:0]      len,
  output logic             busy,
  output logic             done,
  output logic             mem_write_en,
  output logic [31:0]      mem_addr,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Stream handshake: a word transfers on every rising edge where
  // out_valid && out_ready; out_valid never drops and out_data never changes
  // until that transfer happens.

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic [31:0]      base_q;
  logic [15:0]      len_q;
  logic [15:0]      issued;
  logic [15:0]      popped;
  logic             rd_v1;
  logic             rd_v2;
  logic [CW-1:0]    fifo_count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic             start_run;
  logic             start_zero;
  logic             issue_run;
  logic             pop;
  logic             last_pop;
  logic             wr_en;
  logic             done_next;
  logic [1:0]       outstanding;
  logic [CW-1:0]    credit_used;

  // rd_v1/rd_v2 track an issued address through the memory's one-cycle read:
  // the word lands in the FIFO two edges after its issue edge.
  always_comb begin
    outstanding = {1'b0, rd_v1} + {1'b0, rd_v2};
    credit_used = fifo_count + CW'(outstanding);
    start_run   = (state == IDLE) && start && (len != 16'd0);
    start_zero  = (state == IDLE) && start && (len == 16'd0);
    issue_run   = (state == RUN) && (issued < len_q) &&
                  (credit_used < CW'(FIFO_DEPTH));
    pop         = out_valid && out_ready;
    last_pop    = (state == RUN) && pop && (popped == len_q - 16'd1);
    wr_en       = rd_v2;
    done_next   = start_zero || last_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_run) state_next = RUN;
      RUN:     if (last_pop)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transfer bookkeeping and address generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      popped   <= '0;
      mem_addr <= '0;
      rd_v1    <= 1'b0;
      rd_v2    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done  <= done_next;
      rd_v1 <= start_run || issue_run;
      rd_v2 <= rd_v1;
      if (start_run) begin
        base_q   <= base_addr;
        len_q    <= len;
        issued   <= 16'd1;
        popped   <= '0;
        mem_addr <= base_addr;
      end else begin
        if (issue_run) begin
          mem_addr <= base_q + {16'd0, issued};
          issued   <= issued + 16'd1;
        end
        if ((state == RUN) && pop) popped <= popped + 16'd1;
      end
    end
  end

  // Output FIFO; the credit check on issue keeps it from ever overflowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (wr_en) begin
        fifo_mem[wr_ptr] <= mem_data_out;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign busy         = (state == RUN);
  assign mem_write_en = 1'b0;
  assign out_valid    = (fifo_count != '0);
  assign out_data     = fifo_mem[rd_ptr];

endmodule
